rths_row_loader: RTL and testbench
==================================

# rths_row_loader

Serial-to-matrix front end of the RTHS sorter. It accepts one W-bit key per cycle over a valid/ready handshake and assembles a NUM x NUM frame in row-major order. It then presents the frame as NUM parallel row buses, each NUM*W wide, to the row-sort stage that feeds the transposing Switch. The frame is held until the downstream stage takes it.

## Interface
Parameters:
- NUM, 4: lanes per row and number of rows; frame holds NUM*NUM keys; only NUM = 4 is supported, because the output port list is fixed at four rows.
- W, 16: key width in bits.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- in_data, input, W: incoming key.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: loader accepts a key this cycle.
- in_last, input, 1: marks the final key of a short frame; has effect only with RTHS_ROW_LOADER_PAD_EN.
- OUT1..OUT4, output, NUM*W each: rows 0..3; lane j occupies bits [(j+1)*W-1 : j*W].
- out_valid, output, 1: a complete frame is present on OUT1..OUT4.
- out_ready, input, 1: downstream takes the frame.
- out_count, output, $clog2(NUM*NUM)+1: number of real keys in the presented frame.

## Operation
- States:
  - FILL: collecting keys.
  - FULL: presenting a frame.
- Reset:
  - State goes to FILL; slot counter cnt = 0.
  - OUT1..OUT4 = 0; out_valid = 0; out_count = 0.
  - in_ready = 0 while rst is high.
- Accept: a key is accepted when in_valid && in_ready.
- FILL:
  - in_ready = 1.
  - Accepted key k = cnt is written to row k/NUM, lane k%NUM; cnt increments by 1.
  - Acceptance of key NUM*NUM-1 moves the block to FULL, sets out_count = NUM*NUM and resets cnt to 0.
- FULL:
  - in_ready = 0; out_valid = 1.
  - OUT1..OUT4 and out_count hold stable.
  - out_ready = 1 returns the block to FILL on the next edge.
- Drain and load in the same cycle are not allowed: no key is accepted in any FULL cycle, including the cycle in which the frame drains.
- Slots not yet written in the current frame keep their previous values. Downstream uses only a presented frame, so this is harmless.
- No wrap-around inside a frame: cnt never exceeds NUM*NUM-1.
- in_valid with in_ready = 0 is ignored; the upstream stage holds the key until it is accepted.
- Reset asserted mid-frame discards the partial frame and any presented frame. out_valid is 0 on the cycle after the reset edge.

## Timing
- out_valid rises on the first cycle after the handshake of the final key.
- Minimum period per frame: NUM*NUM accept cycles plus 1 present cycle, i.e. 17 cycles at NUM = 4.
- All outputs except in_ready are registered.
- in_ready is decoded from state and rst only; it never depends combinationally on in_valid or out_ready.

## Configuration
- With RTHS_ROW_LOADER_PAD_EN defined:
  - A key accepted with in_last = 1 closes the frame.
  - In the same edge, every unwritten slot (index > k) is loaded with all-ones. All-ones is the maximum key, so pads sort to the tail.
  - out_count = k+1, and the block enters FULL.
  - in_last on key NUM*NUM-1 behaves as a normal full frame.
  - in_last with no handshake has no effect.
- Without RTHS_ROW_LOADER_PAD_EN: in_last is ignored; no padding logic is built; out_count always reads NUM*NUM while out_valid = 1.

## Structure
- Package rths_pkg holds:
  - the NUM and W defaults;
  - the loader state enum {FILL, FULL};
  - the pad-key constant (all-ones of width W);
  - the count-width constant.
- One natural sub-module, rths_slot_decoder: cnt (and the last flag) to a one-hot NUM*NUM slot write-enable, plus a pad mask.
- Frame storage and the FSM stay in rths_row_loader.

## Test plan
- Reset, then keys 0x0000..0x000F back-to-back with in_valid=1:
  - out_valid rises on the cycle after key 15 is accepted.
  - OUT1 = {0x0003,0x0002,0x0001,0x0000}; OUT4 = {0x000F,0x000E,0x000D,0x000C}.
  - out_count = 16.
- Frame presented with out_ready=0 for 5 cycles:
  - Outputs stay stable and in_ready = 0 throughout.
  - Then out_ready=1 for 1 cycle: FILL on the next cycle, with in_ready = 1.
- Random in_valid gaps (50% duty) over 3 frames: row and lane contents match the accepted-order model, and no key is lost or duplicated.
- rst pulsed after 7 accepted keys:
  - Next cycle: out_valid=0, outputs 0, cnt=0.
  - A new 16-key frame then loads correctly from slot 0.
- PAD_EN: 5 keys 0x0A..0x0E, with in_last on the 5th:
  - OUT1 = {0x000D,0x000C,0x000B,0x000A}; OUT2 = {0xFFFF,0xFFFF,0xFFFF,0x000E}.
  - OUT3 and OUT4 all 0xFFFF; out_count = 5.
- Without PAD_EN: same stimulus keeps in FILL (out_valid stays 0) until 16 keys have been accepted.

Source files
------------

// File: rtl/rths_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rths_pkg
// Brief    : Shared defaults, loader state encoding and constants for the
//            RTHS sorter front end.
// Revision : 1.0 - initial release
// ============================================================================
package rths_pkg;

    localparam int NUM_DEF = 4;
    localparam int W_DEF   = 16;

    // Width of a key count that must be able to represent NUM*NUM itself
    localparam int C_CNT_W = $clog2(NUM_DEF * NUM_DEF) + 1;

    // All-ones is the largest key, so pad slots sort to the tail
    localparam logic [W_DEF-1:0] C_PAD_KEY = '1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } loader_state_t;

endpackage : rths_pkg
`default_nettype wire

// File: rtl/rths_slot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rths_slot_decoder
// Brief    : Turns the slot counter into a one-hot write enable and, when
//            RTHS_ROW_LOADER_PAD_EN is defined, a mask of slots to pad.
// Revision : 1.0 - initial release
// ============================================================================
module rths_slot_decoder #(
    parameter int N2    = 16,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_cnt,
    input  logic             i_we,
    input  logic             i_last,
    output logic [N2-1:0]    o_slot_we,
    output logic [N2-1:0]    o_pad_mask
);

    for (genvar j = 0; j < N2; j++) begin : g_slot
        assign o_slot_we[j] = i_we && (i_cnt == IDX_W'(j));
`ifdef RTHS_ROW_LOADER_PAD_EN
        // Every slot beyond the closing key is filled in the same edge
        assign o_pad_mask[j] = i_we && i_last && (IDX_W'(j) > i_cnt);
`else
        assign o_pad_mask[j] = 1'b0;
`endif
    end

`ifndef RTHS_ROW_LOADER_PAD_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

endmodule : rths_slot_decoder
`default_nettype wire

// File: rtl/rths_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : rths_row_loader
// Brief    : Serial key stream to NUM x NUM row-major frame; holds the frame
//            on NUM row buses until downstream accepts it.
//            Optional short-frame padding: RTHS_ROW_LOADER_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rths_row_loader
    import rths_pkg::*;
#(
    parameter int NUM = NUM_DEF,
    parameter int W   = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    output logic [NUM*W-1:0]          OUT1,
    output logic [NUM*W-1:0]          OUT2,
    output logic [NUM*W-1:0]          OUT3,
    output logic [NUM*W-1:0]          OUT4,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM*NUM):0]  out_count
);

    localparam int N2    = NUM * NUM;
    localparam int IDX_W = $clog2(N2);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [W-1:0]     c_pad_key = '1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N2 - 1);

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_count;
    logic [W-1:0]       r_slot [N2];

    logic               w_accept;
    logic               w_last;
    logic               w_close;
    logic [N2-1:0]      w_slot_we;
    logic [N2-1:0]      w_pad_mask;
    logic [NUM-1:0][NUM*W-1:0] w_rows;

`ifdef RTHS_ROW_LOADER_PAD_EN
    assign w_last = in_last;
`else
    assign w_last = 1'b0;
    logic w_unused_last;
    assign w_unused_last = in_last;
`endif

    // in_ready is a pure decode of state and reset, never of the handshakes
    assign in_ready = (r_state == ST_FILL) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && ((r_cnt == c_last_idx) || w_last);

    rths_slot_decoder #(
        .N2    (N2),
        .IDX_W (IDX_W)
    ) u_slot_decoder (
        .i_cnt      (r_cnt),
        .i_we       (w_accept),
        .i_last     (w_last),
        .o_slot_we  (w_slot_we),
        .o_pad_mask (w_pad_mask)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_close)   w_state_nxt = ST_FULL;
            ST_FULL: if (out_ready) w_state_nxt = ST_FILL;
            default:                w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_count <= '0;
            for (int j = 0; j < N2; j++) begin
                r_slot[j] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= w_close ? '0 : r_cnt + 1'b1;
            end
            if (w_close) begin
                r_count <= CNT_W'(r_cnt) + 1'b1;
            end
            for (int j = 0; j < N2; j++) begin
                if (w_slot_we[j]) begin
                    r_slot[j] <= in_data;
                end else if (w_pad_mask[j]) begin
                    r_slot[j] <= c_pad_key;
                end
            end
        end
    end

    for (genvar r = 0; r < NUM; r++) begin : g_row
        for (genvar l = 0; l < NUM; l++) begin : g_lane
            assign w_rows[r][(l+1)*W-1 -: W] = r_slot[r*NUM + l];
        end
    end

    assign OUT1      = w_rows[0];
    assign OUT2      = w_rows[1];
    assign OUT3      = w_rows[2];
    assign OUT4      = w_rows[3];
    assign out_valid = (r_state == ST_FULL);
    assign out_count = r_count;

endmodule : rths_row_loader
`default_nettype wire

// File: tb/tb_rths_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rths_row_loader
// Brief    : Directed self-checking bench for rths_row_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rths_row_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] OUT1, OUT2, OUT3, OUT4;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_count;

    int n_cmp = 0;
    int n_err = 0;

    rths_row_loader #(.NUM(4), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .OUT1      (OUT1),
        .OUT2      (OUT2),
        .OUT3      (OUT3),
        .OUT4      (OUT4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the key until the DUT accepts it; returns just after the accepting edge
    task automatic send_key(input logic [15:0] d, input logic last);
        bit acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < 64 && !acc; i++) begin
            acc = in_ready;
            step();
        end
        if (!acc) check_val("send_timeout", 64'd0, 64'd1);
        in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] pack_row(input logic [15:0] k0, input logic [15:0] k1,
                                             input logic [15:0] k2, input logic [15:0] k3);
        return {k3, k2, k1, k0};
    endfunction

    logic [15:0] keys [16];

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out1", OUT1, 64'd0);
        check_val("rst_out4", OUT4, 64'd0);
        check_val("rst_count", 64'(out_count), 64'd0);
        check_val("fill_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back frame 0x0000..0x000F
        for (int k = 0; k < 15; k++) send_key(16'(k), 1'b0);
        check_val("pre_last_valid", 64'(out_valid), 64'd0);
        send_key(16'h000F, 1'b0);
        in_data  = 16'hBEEF;
        check_val("f0_valid", 64'(out_valid), 64'd1);
        check_val("f0_out1", OUT1, 64'h0003_0002_0001_0000);
        check_val("f0_out4", OUT4, 64'h000F_000E_000D_000C);
        check_val("f0_count", 64'(out_count), 64'd16);

        // Stall 5 cycles with upstream still offering a key
        for (int c = 0; c < 5; c++) begin
            step();
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
            check_val("stall_out2", OUT2, 64'h0007_0006_0005_0004);
            check_val("stall_out3", OUT3, 64'h000B_000A_0009_0008);
        end
        in_valid = 1'b0;
        drain();
        check_val("drain_valid", 64'(out_valid), 64'd0);
        check_val("drain_in_ready", 64'(in_ready), 64'd1);
        check_val("drain_hold_out1", OUT1, 64'h0003_0002_0001_0000);

        // Three frames with random idle gaps
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) begin
                keys[k] = 16'($urandom);
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    step();
                end
                send_key(keys[k], 1'b0);
            end
            in_valid = 1'b0;
            check_val("rnd_valid", 64'(out_valid), 64'd1);
            check_val("rnd_out1", OUT1, pack_row(keys[0], keys[1], keys[2], keys[3]));
            check_val("rnd_out2", OUT2, pack_row(keys[4], keys[5], keys[6], keys[7]));
            check_val("rnd_out3", OUT3, pack_row(keys[8], keys[9], keys[10], keys[11]));
            check_val("rnd_out4", OUT4, pack_row(keys[12], keys[13], keys[14], keys[15]));
            check_val("rnd_count", 64'(out_count), 64'd16);
            drain();
        end

        // Reset mid-frame after 7 keys
        for (int k = 0; k < 7; k++) send_key(16'h0100 + 16'(k), 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("mrst_valid", 64'(out_valid), 64'd0);
        check_val("mrst_out1", OUT1, 64'd0);
        check_val("mrst_out2", OUT2, 64'd0);
        check_val("mrst_count", 64'(out_count), 64'd0);
        for (int k = 0; k < 16; k++) send_key(16'h0200 + 16'(k), 1'b0);
        in_valid = 1'b0;
        check_val("mrst_f_valid", 64'(out_valid), 64'd1);
        check_val("mrst_f_out1", OUT1, 64'h0203_0202_0201_0200);
        check_val("mrst_f_out2", OUT2, 64'h0207_0206_0205_0204);
        check_val("mrst_f_out4", OUT4, 64'h020F_020E_020D_020C);
        drain();

        // Short frame 0x0A..0x0E, last flag on the fifth key
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        for (int k = 0; k < 5; k++) send_key(16'h000A + 16'(k), k == 4);
        in_valid = 1'b0;
`ifdef RTHS_ROW_LOADER_PAD_EN
        check_val("pad_valid", 64'(out_valid), 64'd1);
        check_val("pad_out1", OUT1, 64'h000D_000C_000B_000A);
        check_val("pad_out2", OUT2, 64'hFFFF_FFFF_FFFF_000E);
        check_val("pad_out3", OUT3, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("pad_out4", OUT4, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("pad_count", 64'(out_count), 64'd5);
        drain();
`else
        check_val("nopad_valid", 64'(out_valid), 64'd0);
        check_val("nopad_in_ready", 64'(in_ready), 64'd1);
        for (int k = 5; k < 16; k++) send_key(16'h000A + 16'(k), 1'b0);
        in_valid = 1'b0;
        check_val("nopad_f_valid", 64'(out_valid), 64'd1);
        check_val("nopad_out1", OUT1, 64'h000D_000C_000B_000A);
        check_val("nopad_out2", OUT2, 64'h0011_0010_000F_000E);
        check_val("nopad_count", 64'(out_count), 64'd16);
        drain();
`endif
        check_val("end_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rths_row_loader
`default_nettype wire
